// File: rtl/dma_cfg_pkg.sv
// Shared definitions for the DMA register-programming sequencer: register map,
// message field layout and FSM state encoding.
package dma_cfg_pkg;

  localparam logic [31:0] DMA_REG_SRC   = 32'h0000_0000;
  localparam logic [31:0] DMA_REG_DST   = 32'h0000_0080;
  localparam logic [31:0] DMA_REG_LEN   = 32'h0000_0100;
  localparam logic [31:0] DMA_REG_START = 32'h0000_0180;

  localparam int unsigned CMD_W       = 96;
  localparam int unsigned CMD_FIELD_W = 32;
  localparam int unsigned CMD_SRC_LSB = 0;
  localparam int unsigned CMD_DST_LSB = 32;
  localparam int unsigned CMD_LEN_LSB = 64;

  localparam int unsigned RSP_W       = 34;
  localparam int unsigned RSP_CYC_LSB = 0;
  localparam int unsigned RSP_ERR_BIT = 32;
  localparam int unsigned RSP_TO_BIT  = 33;

  localparam int unsigned B_W        = 6;
  localparam int unsigned B_RESP_LSB = 0;
  localparam int unsigned B_RESP_W   = 2;
  localparam int unsigned B_ID_LSB   = 2;
  localparam int unsigned B_ID_W     = 4;

  localparam logic [8:0] DMA_W_HI = 9'h001;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StWaitDone,
    StRsp
  } state_e;

  function automatic logic [31:0] reg_addr(input logic [1:0] idx);
    logic [31:0] addr;
    addr = DMA_REG_SRC;
    unique case (idx)
      2'd0: addr = DMA_REG_SRC;
      2'd1: addr = DMA_REG_DST;
      2'd2: addr = DMA_REG_LEN;
      2'd3: addr = DMA_REG_START;
      default: addr = DMA_REG_SRC;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/dma_cfg_seq.sv
// Programs the DMA's four registers from one command, then reports status after done.
// Define DMA_CFG_SEQ_TIMEOUT_EN to enable the done-wait watchdog (TIMEOUT_CYC cycles).
module dma_cfg_seq
  import dma_cfg_pkg::*;
#(
  parameter int unsigned AW_W        = 44,
  parameter int unsigned W_W         = 73,
  parameter logic [8:0]  W_HI        = DMA_W_HI,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_msg,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  output logic [AW_W-1:0]  aw_msg,
  output logic             aw_val,
  input  logic             aw_rdy,
  output logic [W_W-1:0]   w_msg,
  output logic             w_val,
  input  logic             w_rdy,
  input  logic [B_W-1:0]   b_msg,
  input  logic             b_val,
  output logic             b_rdy,
  input  logic             done_msg,
  input  logic             done_val,
  output logic             done_rdy,
  output logic [RSP_W-1:0] rsp_msg,
  output logic             rsp_val,
  input  logic             rsp_rdy
);

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [31:0]       src_q, dst_q, len_q;
  logic [31:0]       cycles_q, cycles_d;
  logic              err_q;
  logic              aw_val_q, w_val_q, b_rdy_q, done_rdy_q, rsp_val_q;
  logic [AW_W-1:0]   aw_msg_q;
  logic [W_W-1:0]    w_msg_q;
  logic [RSP_W-1:0]  rsp_msg_q;
  logic [31:0]       wr_val;
  logic              b_err;
  logic              count_en;

`ifdef DMA_CFG_SEQ_TIMEOUT_EN
  logic [31:0]       wd_q;
`endif

  always_comb begin
    // Elapsed time is measured from the start write's address handshake onward.
    count_en = ((state_q == StW) || (state_q == StB) || (state_q == StWaitDone)) &&
               (idx_q == 2'd3);
    cycles_d = cycles_q;
    if (count_en && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_d = cycles_q + 32'd1;
    end
    wr_val = src_q;
    unique case (idx_q)
      2'd0: wr_val = src_q;
      2'd1: wr_val = dst_q;
      2'd2: wr_val = len_q;
      2'd3: wr_val = 32'd1;
      default: wr_val = src_q;
    endcase
    b_err = (b_msg[B_RESP_LSB +: B_RESP_W] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
      aw_val_q   <= 1'b0;
      w_val_q    <= 1'b0;
      b_rdy_q    <= 1'b0;
      done_rdy_q <= 1'b0;
      rsp_val_q  <= 1'b0;
      aw_msg_q   <= '0;
      w_msg_q    <= '0;
      rsp_msg_q  <= '0;
`ifdef DMA_CFG_SEQ_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      cycles_q <= cycles_d;
      unique case (state_q)
        StIdle: begin
          if (cmd_val) begin
            src_q    <= cmd_msg[CMD_SRC_LSB +: CMD_FIELD_W];
            dst_q    <= cmd_msg[CMD_DST_LSB +: CMD_FIELD_W];
            len_q    <= cmd_msg[CMD_LEN_LSB +: CMD_FIELD_W];
            idx_q    <= 2'd0;
            err_q    <= 1'b0;
            cycles_q <= '0;
            aw_val_q <= 1'b1;
            aw_msg_q <= AW_W'(reg_addr(2'd0));
            state_q  <= StAw;
          end
        end
        StAw: begin
          if (aw_rdy) begin
            aw_val_q <= 1'b0;
            w_val_q  <= 1'b1;
            w_msg_q  <= W_W'({W_HI, 32'h0, wr_val});
            state_q  <= StW;
          end
        end
        StW: begin
          if (w_rdy) begin
            w_val_q <= 1'b0;
            b_rdy_q <= 1'b1;
            state_q <= StB;
          end
        end
        StB: begin
          if (b_val) begin
            err_q   <= err_q | b_err;
            b_rdy_q <= 1'b0;
            if (idx_q == 2'd3) begin
              done_rdy_q <= 1'b1;
              state_q    <= StWaitDone;
`ifdef DMA_CFG_SEQ_TIMEOUT_EN
              wd_q       <= '0;
`endif
            end else begin
              idx_q    <= idx_q + 2'd1;
              aw_val_q <= 1'b1;
              aw_msg_q <= AW_W'(reg_addr(idx_q + 2'd1));
              state_q  <= StAw;
            end
          end
        end
        StWaitDone: begin
          if (done_val) begin
            done_rdy_q <= 1'b0;
            rsp_val_q  <= 1'b1;
            rsp_msg_q  <= {1'b0, err_q, cycles_d};
            state_q    <= StRsp;
          end
`ifdef DMA_CFG_SEQ_TIMEOUT_EN
          else if (wd_q == TIMEOUT_CYC - 1) begin
            done_rdy_q <= 1'b0;
            rsp_val_q  <= 1'b1;
            rsp_msg_q  <= {1'b1, err_q, cycles_d};
            state_q    <= StRsp;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
`endif
        end
        StRsp: begin
          if (rsp_rdy) begin
            rsp_val_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_rdy  = (state_q == StIdle);
  assign aw_val   = aw_val_q;
  assign aw_msg   = aw_msg_q;
  assign w_val    = w_val_q;
  assign w_msg    = w_msg_q;
  assign b_rdy    = b_rdy_q;
  assign done_rdy = done_rdy_q;
  assign rsp_val  = rsp_val_q;
  assign rsp_msg  = rsp_msg_q;

  logic unused_in;
  assign unused_in = ^{done_msg, b_msg[B_ID_LSB +: B_ID_W]};

`ifndef DMA_CFG_SEQ_TIMEOUT_EN
  logic unused_to;
  assign unused_to = ^32'(TIMEOUT_CYC);
`endif

endmodule
